sha2_msg_schedule: RTL
======================

# sha2_msg_schedule

- Parametrised SHA-2 message-schedule generator for SHA-256 and SHA-512.
- Accepts one 16-word message block over a valid/ready stream.
- Emits the full schedule W[0..ROUNDS-1], one word per output handshake, with round index and last-word flag.
- Sits between the block packer and the compression round core; the output stream can be backpressured.

## Interface
- WORD_W, 32, word width; legal values 32 (SHA-256) and 64 (SHA-512); any other value is an elaboration error.
- ROUNDS (localparam), 64 when WORD_W=32, 80 when WORD_W=64.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush, active-high.
- in_valid  in  1  in_word is valid.
- in_ready  out  1  block accepts in_word this cycle.
- in_word  in  WORD_W  message word, big-endian-assembled, word 0 first.
- w_valid  out  1  w_word is valid.
- w_ready  in  1  consumer accepts w_word.
- w_word  out  WORD_W  schedule word W[t].
- w_round  out  7  index t of w_word.
- w_last  out  1  high when w_round == ROUNDS-1.

## Operation
- State: 16-entry window win[0..15], round counter cnt (7 bits), FSM {LOAD, EXPAND}, and a registered output slot (w_word, w_round, w_last, w_valid).
- adv = !w_valid | w_ready.
- Push operation: win[i] <= win[i+1] for i = 0..14, and win[15] <= new word.
- LOAD state:
  - in_ready = adv.
  - On in_valid & in_ready: push in_word, load the output slot with in_word, w_round <= cnt, w_valid <= 1, cnt <= cnt+1.
  - When the word with cnt == 15 is accepted: move to EXPAND.
- EXPAND state:
  - in_ready = 0.
  - On adv: compute wn = win[0] + σ0(win[1]) + win[9] + σ1(win[14]) mod 2^WORD_W.
  - Push wn, load the output slot with wn, w_round <= cnt, w_last <= (cnt == ROUNDS-1), cnt <= cnt+1.
  - After cnt == ROUNDS-1 is issued: cnt <= 0 and move to LOAD.
- σ functions:
  - WORD_W=32: σ0 = ROTR7 ^ ROTR18 ^ SHR3; σ1 = ROTR17 ^ ROTR19 ^ SHR10.
  - WORD_W=64: σ0 = ROTR1 ^ ROTR8 ^ SHR7; σ1 = ROTR19 ^ ROTR61 ^ SHR6.
- Output handshake without a reload (w_valid & w_ready, and not adv-with-new-word): w_valid <= 0.
- Stall: while w_valid & !w_ready, every register holds and w_word, w_round and w_last are stable.
- clear:
  - Window, cnt and output slot go to zero; w_valid = 0; state returns to LOAD.
  - An input or output handshake in the same cycle is discarded.
  - rst has priority over clear.
- rst: same values as clear, applied asynchronously. Mid-block reset drops the block; no partial output follows.

## Timing
- Reset values: w_valid 0, w_word 0, w_round 0, w_last 0. in_ready is 1 in the first cycle after rst deasserts.
- Latency: input word to w_word is 1 cycle. Each expanded word takes 1 cycle after the previous output is consumed.
- Throughput: with in_valid and w_ready held high, one block takes ROUNDS cycles (16 LOAD + ROUNDS-16 EXPAND).
- Back-to-back blocks: in the cycle after w_last is issued, in_ready = adv, so the next block's word 0 can be accepted in the cycle w_last is handshaken.
- in_ready depends combinationally on w_ready. There is no combinational path from in_valid to any output.

## Configuration
- SHA2_SCHED_TRACE_EN defined: on every output handshake, a simulation `$display` prints the instance path, time, w_round and w_word in hex.
- Undefined: no simulation-only statements are compiled; the RTL is otherwise identical.

## Structure
- Package sha2_pkg holds:
  - round-count constants (64, 80);
  - σ0/σ1 rotation and shift constants per width;
  - the FSM state enum.
- Sub-module sha2_sigma: combinational σ0/σ1, parametrised by WORD_W. It is shared later with the round core's Σ functions.

## Test plan
- SHA-256 "abc" padded block: W0=0x61626380, W1..W14=0, W15=0x00000018 → W16=0x61626380, W17=0x000F0000, w_last only on w_round=63, 64 words in total.
- SHA-512 "abc": W0=0x6162638000000000, W15=0x18 → W16=0x6162638000000000, W17=0x00030000000000C0, w_last on w_round=79.
- Backpressure: w_ready low for 5 cycles while w_round=20 → w_word and w_round stay constant, in_ready=0, and W21 follows on the first ready cycle.
- Back-to-back: two blocks with in_valid and w_ready held high → 128 consecutive valid cycles, w_round wraps 63→0, no bubble.
- rst asserted at w_round=40 → all outputs 0 immediately, in_ready=1 after release, and the next block starts at w_round=0.
- clear together with in_valid at cnt=5 → word dropped, w_valid=0 next cycle, and the following block restarts at w_round=0.

Source files
------------

// File: rtl/sha2_pkg.sv
// Shared SHA-2 constants: round counts, sigma rotate/shift amounts
// and the message-schedule FSM state type.
package sha2_pkg;

   localparam int ROUNDS_256 = 64;
   localparam int ROUNDS_512 = 80;

   localparam int S256_S0_R1 = 7;
   localparam int S256_S0_R2 = 18;
   localparam int S256_S0_SH = 3;
   localparam int S256_S1_R1 = 17;
   localparam int S256_S1_R2 = 19;
   localparam int S256_S1_SH = 10;

   localparam int S512_S0_R1 = 1;
   localparam int S512_S0_R2 = 8;
   localparam int S512_S0_SH = 7;
   localparam int S512_S1_R1 = 19;
   localparam int S512_S1_R2 = 61;
   localparam int S512_S1_SH = 6;

   typedef enum logic {
      ST_LOAD   = 1'b0,
      ST_EXPAND = 1'b1
   } sched_state_e;

   function automatic int rounds_for(input int word_w);
      return (word_w == 64) ? ROUNDS_512 : ROUNDS_256;
   endfunction

endpackage

// File: rtl/sha2_sigma.sv
// Combinational SHA-2 small sigma; SEL=0 gives sigma0, SEL=1 sigma1.
// Legal widths are 32 (SHA-256) and 64 (SHA-512).
module sha2_sigma
   import sha2_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int SEL    = 0
) (
   input  logic [WORD_W-1:0] x_i,
   output logic [WORD_W-1:0] s_o
);

   if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
      $error("sha2_sigma: WORD_W must be 32 or 64");
   end

   localparam bit W64 = (WORD_W == 64);

   localparam int R1 = W64 ? ((SEL == 0) ? S512_S0_R1 : S512_S1_R1)
                           : ((SEL == 0) ? S256_S0_R1 : S256_S1_R1);
   localparam int R2 = W64 ? ((SEL == 0) ? S512_S0_R2 : S512_S1_R2)
                           : ((SEL == 0) ? S256_S0_R2 : S256_S1_R2);
   localparam int SH = W64 ? ((SEL == 0) ? S512_S0_SH : S512_S1_SH)
                           : ((SEL == 0) ? S256_S0_SH : S256_S1_SH);

   function automatic logic [WORD_W-1:0] rotr(
      input logic [WORD_W-1:0] x,
      input int                r
   );
      return (x >> r) | (x << (WORD_W - r));
   endfunction

   assign s_o = rotr(x_i, R1) ^ rotr(x_i, R2) ^ (x_i >> SH);

endmodule

// File: rtl/sha2_msg_schedule.sv
// SHA-2 message schedule: loads 16 words, expands to W[0..ROUNDS-1].
// Define SHA2_SCHED_TRACE_EN to print every output handshake.
module sha2_msg_schedule
   import sha2_pkg::*;
#(
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_word,
   output logic              w_valid,
   input  logic              w_ready,
   output logic [WORD_W-1:0] w_word,
   output logic [6:0]        w_round,
   output logic              w_last
);

   if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
      $error("sha2_msg_schedule: WORD_W must be 32 or 64");
   end

   localparam int          ROUNDS   = rounds_for(WORD_W);
   localparam logic [6:0]  LAST_RND = 7'(ROUNDS - 1);
   localparam logic [6:0]  LAST_LD  = 7'd15;

   sched_state_e      state_q, state_d;
   logic [WORD_W-1:0] win_q [16];
   logic [WORD_W-1:0] win_d [16];
   logic [6:0]        cnt_q, cnt_d;
   logic [WORD_W-1:0] w_word_q, w_word_d;
   logic [6:0]        w_round_q, w_round_d;
   logic              w_last_q, w_last_d;
   logic              w_valid_q, w_valid_d;

   logic              adv;
   logic              push;
   logic [WORD_W-1:0] new_word;
   logic [WORD_W-1:0] s0, s1, wn;

   sha2_sigma #(.WORD_W(WORD_W), .SEL(0)) u_s0 (
      .x_i (win_q[1]),
      .s_o (s0)
   );

   sha2_sigma #(.WORD_W(WORD_W), .SEL(1)) u_s1 (
      .x_i (win_q[14]),
      .s_o (s1)
   );

   assign wn  = win_q[0] + s0 + win_q[9] + s1;
   assign adv = !w_valid_q || w_ready;

   assign in_ready = (state_q == ST_LOAD) && adv;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      w_word_d  = w_word_q;
      w_round_d = w_round_q;
      w_last_d  = w_last_q;
      w_valid_d = w_valid_q;
      for (int i = 0; i < 16; i++) win_d[i] = win_q[i];
      push     = 1'b0;
      new_word = '0;

      if (state_q == ST_LOAD) begin
         if (in_valid && in_ready) begin
            push     = 1'b1;
            new_word = in_word;
         end
      end else if (adv) begin
         push     = 1'b1;
         new_word = wn;
      end

      if (push) begin
         for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
         win_d[15] = new_word;
         w_word_d  = new_word;
         w_round_d = cnt_q;
         w_last_d  = (state_q == ST_EXPAND) && (cnt_q == LAST_RND);
         w_valid_d = 1'b1;
         cnt_d     = cnt_q + 7'd1;
         if (state_q == ST_LOAD && cnt_q == LAST_LD)
            state_d = ST_EXPAND;
         if (state_q == ST_EXPAND && cnt_q == LAST_RND) begin
            cnt_d   = '0;
            state_d = ST_LOAD;
         end
      end else if (w_valid_q && w_ready) begin
         w_valid_d = 1'b0;
      end

      // Flush overrides any handshake taken in the same cycle.
      if (clear) begin
         state_d   = ST_LOAD;
         cnt_d     = '0;
         w_word_d  = '0;
         w_round_d = '0;
         w_last_d  = 1'b0;
         w_valid_d = 1'b0;
         for (int i = 0; i < 16; i++) win_d[i] = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_LOAD;
         cnt_q     <= '0;
         w_word_q  <= '0;
         w_round_q <= '0;
         w_last_q  <= 1'b0;
         w_valid_q <= 1'b0;
         for (int i = 0; i < 16; i++) win_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         w_word_q  <= w_word_d;
         w_round_q <= w_round_d;
         w_last_q  <= w_last_d;
         w_valid_q <= w_valid_d;
         for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
      end
   end

   assign w_valid = w_valid_q;
   assign w_word  = w_word_q;
   assign w_round = w_round_q;
   assign w_last  = w_last_q;

`ifdef SHA2_SCHED_TRACE_EN
   always_ff @(posedge clk) begin
      if (!rst && w_valid_q && w_ready)
         $display("%m t=%0t round=%0d w=%h", $time, w_round_q, w_word_q);
   end
`else
`endif

endmodule
